// File: rtl/cpu_mem_pkg.sv
// Shared types and default widths for the control unit's data-memory path.
package cpu_mem_pkg;
  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    RESP = 2'b10
  } state_t;
endpackage

// File: rtl/mem_responder_if.sv
// Request/response bundle between the control unit (master) and the data memory (slave).
interface mem_responder_if
  import cpu_mem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_we;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_we, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_we, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/mem_array.sv
// DEPTH x DATA_W storage: synchronous write, combinational read on a shared address.
module mem_array #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 256,
  parameter int IDX_W  = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];
endmodule

// File: rtl/mem_responder.sv
// Data-memory responder: one request at a time, response after WAIT_CYCLES of wait.
// Optional MEM_BOUNDS_CHECK_EN flags addresses >= DEPTH instead of wrapping (DEPTH a power of two).
module mem_responder
  import cpu_mem_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 1
) (
  input logic            clk,
  input logic            reset_n,
  mem_responder_if.slave bus
);
  localparam int         IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  state_t            state_p0, state_nxt;
  logic [3:0]        cnt_p0, cnt_nxt;
  logic              rsp_we_p0, rsp_err_p0;
  logic [DATA_W-1:0] rsp_rdata_p0;
  logic              req_ready, rsp_valid, accept, in_range, mem_we;
  logic [DATA_W-1:0] rd_data;
  logic              unused_addr_hi;

  assign unused_addr_hi = ^bus.req_addr;

`ifdef MEM_BOUNDS_CHECK_EN
  assign in_range = 32'(bus.req_addr) < 32'(DEPTH);
`else
  assign in_range = 1'b1;
`endif

  // Store commits on the same edge that accepts the request.
  assign accept = req_ready && bus.req_valid;
  assign mem_we = accept && bus.req_we && in_range;

  mem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_array (
    .clk   (clk),
    .we    (mem_we),
    .addr  (bus.req_addr[IDX_W-1:0]),
    .wdata (bus.req_wdata),
    .rdata (rd_data)
  );

  always_comb begin
    state_nxt = state_p0;
    cnt_nxt   = cnt_p0;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    case (state_p0)
      IDLE: begin
        req_ready = 1'b1;
        if (bus.req_valid) begin
          if (WAIT_CYCLES == 0) begin
            state_nxt = RESP;
          end else begin
            state_nxt = WAIT;
            cnt_nxt   = WAIT_INIT;
          end
        end
      end
      WAIT: begin
        if (cnt_p0 == 4'd0) state_nxt = RESP;
        else                cnt_nxt   = cnt_p0 - 4'd1;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (bus.rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Accept edge -> response registers held through WAIT and RESP
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_p0     <= IDLE;
      cnt_p0       <= 4'd0;
      rsp_we_p0    <= 1'b0;
      rsp_err_p0   <= 1'b0;
      rsp_rdata_p0 <= '0;
    end else begin
      state_p0 <= state_nxt;
      cnt_p0   <= cnt_nxt;
      if (accept) begin
        rsp_we_p0    <= bus.req_we;
        rsp_err_p0   <= !in_range;
        rsp_rdata_p0 <= (bus.req_we || !in_range) ? '0 : rd_data;
      end
    end
  end

  assign bus.req_ready = req_ready;
  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_we    = rsp_we_p0;
  assign bus.rsp_err   = rsp_err_p0;
  assign bus.rsp_rdata = rsp_rdata_p0;
endmodule
